// File: rtl/mag_sequencer.sv
// mag_sequencer: streams alpha-max-plus-beta-min magnitudes of FFT bins to the line buffer.
// Optional peak tracker is built when MAG_SEQUENCER_PEAK_EN is defined.
module mag_sequencer #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6,
    parameter int BINS   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fft_rd,
    output logic [ADDR_W-1:0] fft_addr,
    input  logic [WIDTH-1:0]  fft_r,
    input  logic [WIDTH-1:0]  fft_i,
    output logic              mag_we,
    output logic [ADDR_W-1:0] mag_addr,
    output logic [WIDTH-1:0]  mag_data,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  peak_mag,
    output logic [ADDR_W-1:0] peak_bin
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] NBINS = CW'(BINS);
    localparam logic [CW-1:0] LAST  = CW'(BINS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_rd_cnt;
    logic [CW-1:0]    r_wr_cnt;
    logic             r_rd_d;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_skid;

    logic             w_start;
    logic             w_acc;
    logic             w_last_acc;
    logic             w_rd;
    logic [1:0]       w_occ;

    logic [WIDTH:0]   w_re;
    logic [WIDTH:0]   w_im;
    logic [WIDTH:0]   w_a;
    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_mx;
    logic [WIDTH:0]   w_mn;
    logic [WIDTH-1:0] w_mag;

    // |x| at WIDTH+1 bits keeps the most negative input exact
    assign w_re  = {fft_r[WIDTH-1], fft_r};
    assign w_im  = {fft_i[WIDTH-1], fft_i};
    assign w_a   = w_re[WIDTH] ? -w_re : w_re;
    assign w_b   = w_im[WIDTH] ? -w_im : w_im;
    assign w_mx  = (w_a > w_b) ? w_a : w_b;
    assign w_mn  = (w_a > w_b) ? w_b : w_a;
    assign w_mag = WIDTH'(w_mx + (w_mn >> 1));

    assign w_start    = (r_state == S_IDLE) && start;
    assign w_acc      = mag_we && out_ready;
    assign w_last_acc = w_acc && (r_wr_cnt == LAST);
    assign w_occ      = r_cnt + {1'b0, r_rd_d};
    assign w_rd       = (r_state == S_RUN) && (r_rd_cnt < NBINS) &&
                        ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_acc));

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign fft_rd   = w_rd;
    assign fft_addr = r_rd_cnt[ADDR_W-1:0];
    assign mag_we   = (r_cnt != 2'd0);
    assign mag_addr = r_wr_cnt[ADDR_W-1:0];
    assign mag_data = r_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN:  if (w_last_acc) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_rd_d   <= 1'b0;
        end else begin
            if (w_start || (r_state == S_DONE)) begin
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_rd)  r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            r_rd_d <= w_rd;
        end
    end

    // Output register plus one skid entry; returning data is always pushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 2'd0;
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            unique case ({r_rd_d, w_acc})
                2'b10: begin
                    if (r_cnt == 2'd0) r_out  <= w_mag;
                    else               r_skid <= w_mag;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) r_out <= r_skid;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_out <= w_mag;
                    end else begin
                        r_out  <= r_skid;
                        r_skid <= w_mag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MAG_SEQUENCER_PEAK_EN
    logic [WIDTH-1:0]  r_run_mag;
    logic [ADDR_W-1:0] r_run_bin;
    logic [WIDTH-1:0]  r_peak_mag;
    logic [ADDR_W-1:0] r_peak_bin;
    logic              w_gt;

    // Strictly greater keeps the lowest bin on ties
    assign w_gt = w_acc && (mag_data > r_run_mag);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_mag  <= '0;
            r_run_bin  <= '0;
            r_peak_mag <= '0;
            r_peak_bin <= '0;
        end else begin
            if (w_start) begin
                r_run_mag <= '0;
                r_run_bin <= '0;
            end else if (w_gt) begin
                r_run_mag <= mag_data;
                r_run_bin <= mag_addr;
            end
            if (w_last_acc) begin
                r_peak_mag <= w_gt ? mag_data : r_run_mag;
                r_peak_bin <= w_gt ? mag_addr : r_run_bin;
            end
        end
    end

    assign peak_mag = r_peak_mag;
    assign peak_bin = r_peak_bin;
`else
    assign peak_mag = '0;
    assign peak_bin = '0;
`endif

endmodule

// File: tb/tb_mag_sequencer.sv
// tb_mag_sequencer: directed frames against mag_sequencer with a registered FFT RAM model.
// Peak expectations follow MAG_SEQUENCER_PEAK_EN.
module tb_mag_sequencer;
    localparam int W  = 16;
    localparam int AW = 6;
    localparam int NB = 32;

`ifdef MAG_SEQUENCER_PEAK_EN
    localparam int PK_MAG = 1000;
    localparam int PK_BIN = 5;
`else
    localparam int PK_MAG = 0;
    localparam int PK_BIN = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, fft_rd, mag_we;
    logic [AW-1:0] fft_addr, mag_addr, peak_bin;
    logic [W-1:0]  fft_r, fft_i, mag_data, peak_mag;

    mag_sequencer #(.WIDTH(W), .ADDR_W(AW), .BINS(NB)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fft_rd   (fft_rd),
        .fft_addr (fft_addr),
        .fft_r    (fft_r),
        .fft_i    (fft_i),
        .mag_we   (mag_we),
        .mag_addr (mag_addr),
        .mag_data (mag_data),
        .out_ready(out_ready),
        .peak_mag (peak_mag),
        .peak_bin (peak_bin)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem_r [64];
    logic [W-1:0] mem_i [64];
    logic [W-1:0] exp_mag [NB];

    always @(posedge clk) begin
        if (fft_rd) begin
            fft_r <= mem_r[fft_addr];
            fft_i <= mem_i[fft_addr];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0 = 0;
    int rd_n, wr_n, rd_first, rd_last, we_first, we_last;
    int done_at, done_n, busy_n, max_out, stab_bad;
    logic busy_at_done;
    logic [W-1:0]  pk_mag;
    logic [AW-1:0] pk_bin;
    logic [AW-1:0] wa_q [$];
    logic [W-1:0]  wd_q [$];
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [W-1:0]  prev_data;

    task automatic clear_stats();
        rd_n = 0; wr_n = 0; rd_first = -1; rd_last = -1;
        we_first = -1; we_last = -1; done_at = -1; done_n = 0;
        busy_n = 0; max_out = 0; stab_bad = 0; busy_at_done = 1'b1;
        prev_stall = 1'b0; pk_mag = '0; pk_bin = '0;
        wa_q.delete(); wd_q.delete();
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (fft_rd) begin
            if (rd_first < 0) rd_first = rel;
            rd_last = rel;
            rd_n++;
        end
        if (prev_stall && (!mag_we || mag_addr != prev_addr ||
                           mag_data != prev_data)) stab_bad++;
        if (mag_we) begin
            if (we_first < 0) we_first = rel;
            we_last = rel;
        end
        if (mag_we && out_ready) begin
            wa_q.push_back(mag_addr);
            wd_q.push_back(mag_data);
            wr_n++;
        end
        if (rd_n - wr_n > max_out) max_out = rd_n - wr_n;
        prev_stall = mag_we && !out_ready;
        prev_addr  = mag_addr;
        prev_data  = mag_data;
        if (busy) busy_n++;
        if (done) begin
            done_n++;
            done_at = rel;
            busy_at_done = busy;
            pk_mag = peak_mag;
            pk_bin = peak_bin;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < NB; k++) begin
            mem_r[k]   = W'(k);
            mem_i[k]   = W'(-2 * k);
            exp_mag[k] = W'(2 * k + (k >> 1));
        end
    endtask

    // mode 0: always ready; mode 1: random ready with a forced 5-cycle stall
    task automatic run_frame(input int mode, input int restart_at);
        clear_stats();
        t0 = cyc;
        start = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k < 400 && done_n == 0; k++) begin
            tick();
            start = (k == restart_at);
            if (mode == 1)
                out_ready = (k >= 12 && k < 17) ? 1'b0 :
                            ($urandom_range(0, 2) != 0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", done_n, 1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wr_n, NB);
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), wa_q[k], k);
            check($sformatf("%s_data%0d", tag, k), wd_q[k], exp_mag[k]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fft_rd"}, fft_rd, 0);
        check({tag, "_fft_addr"}, fft_addr, 0);
        check({tag, "_mag_we"}, mag_we, 0);
        check({tag, "_mag_addr"}, mag_addr, 0);
        check({tag, "_mag_data"}, mag_data, 0);
        check({tag, "_peak_mag"}, peak_mag, 0);
        check({tag, "_peak_bin"}, peak_bin, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem_r[k] = '0;
            mem_i[k] = '0;
        end
        clear_stats();
        tick();
        tick();
        check_idle_outputs("rst");
        reset_n = 1'b1;
        tick();
        clear_stats();
        for (int k = 0; k < 10; k++) tick();
        check("idle_rd", rd_n, 0);
        check("idle_we", wr_n, 0);
        check("idle_busy", busy_n, 0);

        // full frame with a start pulse during RUN
        load_ramp();
        run_frame(0, 5);
        check("a_rd_first", rd_first, 1);
        check("a_rd_last", rd_last, NB);
        check("a_rd_n", rd_n, NB);
        check("a_we_first", we_first, 3);
        check("a_we_last", we_last, NB + 2);
        check("a_done_at", done_at, NB + 3);
        check("a_busy_cycles", busy_n, NB + 2);
        check("a_busy_at_done", busy_at_done, 0);
        check_writes("a");
        for (int k = 0; k < 5; k++) tick();
        check("a_no_requeue_busy", busy, 0);
        check("a_done_once", done_n, 1);

        // arithmetic corners in bins 0..4
        load_ramp();
        mem_r[0] = 16'h8000; mem_i[0] = 16'h8000; exp_mag[0] = 16'd49152;
        mem_r[1] = 16'h7fff; mem_i[1] = 16'h0000; exp_mag[1] = 16'd32767;
        mem_r[2] = 16'h8000; mem_i[2] = 16'h0001; exp_mag[2] = 16'd32768;
        mem_r[3] = 16'h0000; mem_i[3] = 16'h0000; exp_mag[3] = 16'd0;
        mem_r[4] = 16'h0003; mem_i[4] = 16'h0003; exp_mag[4] = 16'd4;
        tick();
        run_frame(0, 0);
        check_writes("corner");

        // backpressure
        load_ramp();
        tick();
        run_frame(1, 0);
        check_writes("bp");
        check("bp_stable", stab_bad, 0);
        check("bp_outst_le2", (max_out <= 2), 1);
        check("bp_rd_n", rd_n, NB);

        // peak tracker: bins 5 and 9 tie at 1000
        for (int k = 0; k < NB; k++) begin
            mem_r[k] = W'(k);
            mem_i[k] = '0;
            exp_mag[k] = W'(k);
        end
        mem_r[5] = 16'd1000; exp_mag[5] = 16'd1000;
        mem_r[9] = 16'd1000; exp_mag[9] = 16'd1000;
        tick();
        run_frame(0, 0);
        check_writes("pk");
        check("pk_mag_at_done", pk_mag, PK_MAG);
        check("pk_bin_at_done", pk_bin, PK_BIN);
        for (int k = 0; k < 3; k++) tick();
        check("pk_mag_hold", peak_mag, PK_MAG);
        check("pk_bin_hold", peak_bin, PK_BIN);

        // reset mid-frame, then a clean frame
        load_ramp();
        tick();
        clear_stats();
        t0 = cyc;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_no_done", done_n, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_frame(0, 0);
        check("post_rst_done_at", done_at, NB + 3);
        check_writes("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
